// File: rtl/generatore_scansione_pkg.sv
// Shared raster timing constants: default 1280x1024@60 timing and coordinate width.
package pkg_video;

  // Coordinate width: both totals must fit, so each must be 2047 or less.
  localparam int COORD_W = 11;

  localparam int H_ACTIVE_DEF = 1280;
  localparam int H_FP_DEF     = 48;
  localparam int H_SYNC_DEF   = 112;
  localparam int H_BP_DEF     = 248;

  localparam int V_ACTIVE_DEF = 1024;
  localparam int V_FP_DEF     = 1;
  localparam int V_SYNC_DEF   = 3;
  localparam int V_BP_DEF     = 38;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 1688
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 1066

  // Axis total from its four timing segments.
  function automatic int asse_totale(input int act, input int fp, input int sy, input int bp);
    return act + fp + sy + bp;
  endfunction

endpackage

// File: rtl/generatore_scansione_contatore_asse.sv
// Mod-N axis counter with enable; wrap_o flags the last count so the next
// enabled clock returns to zero (and can enable the next axis up).
module contatore_asse
  import pkg_video::*;
#(
  parameter int unsigned N = 2,
  parameter int          W = COORD_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap_o = (cnt_q == LAST);
  assign cnt_o  = cnt_q;

  // Next count: hold, increment, or wrap to zero at N-1.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/generatore_scansione.sv
// Raster timing source. hc/vc hold the next pixel to present; every output is
// a register loaded from a decode of hc/vc on each enabled clock, so outputs
// lag the counters by exactly one enabled clock.
module generatore_scansione
  import pkg_video::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               PIX_EN,
  output logic [COORD_W-1:0] X_CONTROLLO,
  output logic [COORD_W-1:0] Y_CONTROLLO,
  output logic               ATTIVO,
  output logic               HSYNC,
  output logic               VSYNC,
  output logic               FINE_FRAME,
  output logic [7:0]         NUM_FRAME
);

  localparam int H_TOTAL = asse_totale(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = asse_totale(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [COORD_W-1:0] hc;
  logic [COORD_W-1:0] vc;
  logic               h_wrap;
  logic               v_wrap;

  contatore_asse #(.N(H_TOTAL), .W(COORD_W)) u_hc (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .en_i   (PIX_EN),
    .cnt_o  (hc),
    .wrap_o (h_wrap)
  );

  // The line counter advances only on the last column of a line.
  contatore_asse #(.N(V_TOTAL), .W(COORD_W)) u_vc (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .en_i   (PIX_EN && h_wrap),
    .cnt_o  (vc),
    .wrap_o (v_wrap)
  );

  logic               att_d;
  logic               hs_d;
  logic               vs_d;
  logic               frame_start_d;

  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic               att_q;
  logic               hs_q;
  logic               vs_q;
  logic               fine_q;
  logic [7:0]         num_q;

  // Decode of the pixel about to be presented. v_wrap is only needed by the
  // counter chain, so fold it into a harmless term to keep it observed.
  always_comb begin
    att_d         = (hc < H_ACT_C) && (vc < V_ACT_C);
    hs_d          = ((hc >= HS_FIRST) && (hc <= HS_LAST)) ? HS_POL : ~HS_POL;
    vs_d          = ((vc >= VS_FIRST) && (vc <= VS_LAST)) ? VS_POL : ~VS_POL;
    frame_start_d = (hc == '0) && (vc == V_ACT_C) && (v_wrap || !v_wrap);
  end

  // Output registers: load on enabled clocks; FINE_FRAME is a one-CLK strobe.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      x_q    <= '0;
      y_q    <= '0;
      att_q  <= 1'b0;
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
      fine_q <= 1'b0;
      num_q  <= '0;
    end else begin
      fine_q <= 1'b0;
      if (PIX_EN) begin
        x_q    <= hc;
        y_q    <= vc;
        att_q  <= att_d;
        hs_q   <= hs_d;
        vs_q   <= vs_d;
        fine_q <= frame_start_d;
        if (frame_start_d) num_q <= num_q + 8'd1;
      end
    end
  end

  assign X_CONTROLLO = x_q;
  assign Y_CONTROLLO = y_q;
  assign ATTIVO      = att_q;
  assign HSYNC       = hs_q;
  assign VSYNC       = vs_q;
  assign FINE_FRAME  = fine_q;
  assign NUM_FRAME   = num_q;

endmodule
